// File: rtl/dqs_dly_train_ctrl.sv
// -----------------------------------------------------------------------------
// dqs_dly_train_ctrl
//
// Purpose
//   Trains the static delay of one DQS lane IOD delay line. After a START
//   request the controller reloads the delay line and then repeats this loop:
//   clear the IOD eye-monitor flags, wait, and sample the flags. Depending on
//   the flags it then steps the delay one tap, clears again, or counts a clean
//   sample. LOCK_COUNT consecutive clean samples declare lock (DONE). An
//   out-of-range flag from the delay line, or a tap offset that would leave the
//   signed 8-bit range, ends training in FAIL.
//
// Configuration macro
//   DQS_DLY_TRAIN_STEP_LIMIT_EN : when defined, the number of moves since LOAD
//                                 is counted. A SAMPLE taken once that count
//                                 equals MAX_STEPS goes to FAIL. When undefined
//                                 the move counter does not exist.
//
// Parameters
//   WAIT_CYCLES : FAB_CLK cycles spent in WAIT between flag clear and sample (2..255)
//   LOCK_COUNT  : consecutive clean samples needed for lock (1..15)
//   MAX_STEPS   : move limit, used only with the step-limit macro (1..255)
//
// Ports
//   FAB_CLK                 in  : single clock, rising edge
//   ARST_N                  in  : asynchronous assert, active-low reset
//   START                   in  : level-sampled training request (IDLE/DONE/FAIL only)
//   EYE_MONITOR_EARLY       in  : IOD early flag
//   EYE_MONITOR_LATE        in  : IOD late flag
//   DELAY_LINE_OUT_OF_RANGE in  : IOD delay-line limit flag
//   DELAY_LINE_LOAD         out : 1-cycle pulse, reload static delay
//   DELAY_LINE_MOVE         out : 1-cycle pulse, step delay by one tap
//   DELAY_LINE_DIRECTION    out : 1 = increase delay, 0 = decrease delay
//   EYE_MONITOR_CLEAR_FLAGS out : 1-cycle pulse, clear IOD flags
//   BUSY / DONE / FAIL      out : training status
//   TAP_OFFSET              out : signed net taps moved since LOAD
//
// Every output comes straight from a flop; the status and pulse flops are
// loaded from the decoded next state, so each pulse is high exactly during
// the cycle the FSM spends in the matching state.
// -----------------------------------------------------------------------------
module dqs_dly_train_ctrl #(
    parameter int WAIT_CYCLES = 16,
    parameter int LOCK_COUNT  = 4,
    parameter int MAX_STEPS   = 127
) (
    input  logic       FAB_CLK,
    input  logic       ARST_N,
    input  logic       START,
    input  logic       EYE_MONITOR_EARLY,
    input  logic       EYE_MONITOR_LATE,
    input  logic       DELAY_LINE_OUT_OF_RANGE,
    output logic       DELAY_LINE_LOAD,
    output logic       DELAY_LINE_MOVE,
    output logic       DELAY_LINE_DIRECTION,
    output logic       EYE_MONITOR_CLEAR_FLAGS,
    output logic       BUSY,
    output logic       DONE,
    output logic       FAIL,
    output logic [7:0] TAP_OFFSET
);

    // -------------------------------------------------------------------------
    // State encoding
    // -------------------------------------------------------------------------
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_CLEAR  = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_SAMPLE = 3'd4;
    localparam logic [2:0] S_MOVE   = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;
    localparam logic [2:0] S_FAIL   = 3'd7;

    // WAIT occupies counts 0..WAIT_CYCLES-1, i.e. exactly WAIT_CYCLES cycles.
    localparam logic [7:0]        WAIT_LAST   = 8'(WAIT_CYCLES - 1);
    localparam logic [3:0]        LOCK_TARGET = 4'(LOCK_COUNT);
    localparam logic signed [7:0] TAP_MAX     = 8'sd127;
    localparam logic signed [7:0] TAP_MIN     = 8'sh80;   // -128

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    logic [2:0]        state_q,    state_d;
    logic [7:0]        wait_cnt_q, wait_cnt_d;
    logic [3:0]        lock_cnt_q, lock_cnt_d;
    logic signed [7:0] tap_q,      tap_d;
    logic              dir_q,      dir_d;

    // Registered outputs, loaded from the decoded next state.
    logic load_q,  load_d;
    logic move_q,  move_d;
    logic clear_q, clear_d;
    logic busy_q,  busy_d;
    logic done_q,  done_d;
    logic fail_q,  fail_d;

    logic [3:0] lock_inc;
    logic       step_limit_hit;

    assign lock_inc = lock_cnt_q + 4'd1;

`ifdef DQS_DLY_TRAIN_STEP_LIMIT_EN
    localparam logic [7:0] STEP_LIMIT = 8'(MAX_STEPS);

    logic [7:0] step_cnt_q, step_cnt_d;

    // Checked at SAMPLE before the flags, so once the budget is spent no
    // further move can be issued regardless of what the eye monitor reports.
    assign step_limit_hit = (step_cnt_q == STEP_LIMIT);
`else
    // MAX_STEPS only matters with the move counter present.
    logic unused_max_steps;
    assign unused_max_steps = (MAX_STEPS != 0);
    assign step_limit_hit   = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        lock_cnt_d = lock_cnt_q;
        tap_d      = tap_q;
        dir_d      = dir_q;
`ifdef DQS_DLY_TRAIN_STEP_LIMIT_EN
        step_cnt_d = step_cnt_q;
`endif

        case (state_q)
            S_IDLE, S_DONE, S_FAIL: begin
                if (START) begin
                    state_d    = S_LOAD;
                    // Cleared on entry so TAP_OFFSET already reads 0 while the
                    // LOAD pulse is on the wire.
                    tap_d      = '0;
                    lock_cnt_d = '0;
`ifdef DQS_DLY_TRAIN_STEP_LIMIT_EN
                    step_cnt_d = '0;
`endif
                end
            end

            S_LOAD: begin
                state_d = S_CLEAR;
            end

            S_CLEAR: begin
                wait_cnt_d = '0;
                state_d    = S_WAIT;
            end

            S_WAIT: begin
                if (wait_cnt_q == WAIT_LAST) begin
                    state_d = S_SAMPLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end

            S_SAMPLE: begin
                if (DELAY_LINE_OUT_OF_RANGE || step_limit_hit) begin
                    state_d = S_FAIL;
                end else if (EYE_MONITOR_EARLY && EYE_MONITOR_LATE) begin
                    // Contradictory flags: distrust this sample and retry.
                    lock_cnt_d = '0;
                    state_d    = S_CLEAR;
                end else if (EYE_MONITOR_EARLY) begin
                    if (tap_q == TAP_MAX) begin
                        state_d = S_FAIL;
                    end else begin
                        // Offset is updated on entry so it changes in the
                        // same cycle the MOVE pulse is presented.
                        dir_d      = 1'b1;
                        tap_d      = tap_q + 8'sd1;
                        lock_cnt_d = '0;
`ifdef DQS_DLY_TRAIN_STEP_LIMIT_EN
                        step_cnt_d = step_cnt_q + 8'd1;
`endif
                        state_d    = S_MOVE;
                    end
                end else if (EYE_MONITOR_LATE) begin
                    if (tap_q == TAP_MIN) begin
                        state_d = S_FAIL;
                    end else begin
                        dir_d      = 1'b0;
                        tap_d      = tap_q - 8'sd1;
                        lock_cnt_d = '0;
`ifdef DQS_DLY_TRAIN_STEP_LIMIT_EN
                        step_cnt_d = step_cnt_q + 8'd1;
`endif
                        state_d    = S_MOVE;
                    end
                end else begin
                    lock_cnt_d = lock_inc;
                    if (lock_inc == LOCK_TARGET) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_CLEAR;
                    end
                end
            end

            S_MOVE: begin
                state_d = S_CLEAR;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output decode from the next state (registered below)
    // -------------------------------------------------------------------------
    always_comb begin
        load_d  = (state_d == S_LOAD);
        move_d  = (state_d == S_MOVE);
        clear_d = (state_d == S_CLEAR);
        busy_d  = (state_d == S_LOAD)  || (state_d == S_CLEAR) ||
                  (state_d == S_WAIT)  || (state_d == S_SAMPLE) ||
                  (state_d == S_MOVE);
        done_d  = (state_d == S_DONE);
        fail_d  = (state_d == S_FAIL);
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= '0;
            lock_cnt_q <= '0;
            tap_q      <= '0;
            dir_q      <= 1'b0;
            load_q     <= 1'b0;
            move_q     <= 1'b0;
            clear_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            fail_q     <= 1'b0;
`ifdef DQS_DLY_TRAIN_STEP_LIMIT_EN
            step_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            lock_cnt_q <= lock_cnt_d;
            tap_q      <= tap_d;
            dir_q      <= dir_d;
            load_q     <= load_d;
            move_q     <= move_d;
            clear_q    <= clear_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            fail_q     <= fail_d;
`ifdef DQS_DLY_TRAIN_STEP_LIMIT_EN
            step_cnt_q <= step_cnt_d;
`endif
        end
    end

    assign DELAY_LINE_LOAD         = load_q;
    assign DELAY_LINE_MOVE         = move_q;
    assign DELAY_LINE_DIRECTION    = dir_q;
    assign EYE_MONITOR_CLEAR_FLAGS = clear_q;
    assign BUSY                    = busy_q;
    assign DONE                    = done_q;
    assign FAIL                    = fail_q;
    assign TAP_OFFSET              = tap_q;

endmodule

// File: tb/tb_dqs_dly_train_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dqs_dly_train_ctrl
//
// Directed and randomized training runs against dqs_dly_train_ctrl. Each run
// consumes a queue of per-sample flag triples {oor, late, early}; an empty
// queue means clean samples. The reference model works one sample at a time
// on the training rules (tap arithmetic, lock counting, fail conditions) and
// predicts what the outputs must show in the cycle after each sample.
// -----------------------------------------------------------------------------
module tb_dqs_dly_train_ctrl;

    localparam int W    = 3;
    localparam int LOCK = 4;
    localparam int MAXS = 5;

    logic       FAB_CLK;
    logic       ARST_N;
    logic       START;
    logic       EYE_MONITOR_EARLY;
    logic       EYE_MONITOR_LATE;
    logic       DELAY_LINE_OUT_OF_RANGE;
    logic       DELAY_LINE_LOAD;
    logic       DELAY_LINE_MOVE;
    logic       DELAY_LINE_DIRECTION;
    logic       EYE_MONITOR_CLEAR_FLAGS;
    logic       BUSY;
    logic       DONE;
    logic       FAIL;
    logic [7:0] TAP_OFFSET;

    dqs_dly_train_ctrl #(
        .WAIT_CYCLES (W),
        .LOCK_COUNT  (LOCK),
        .MAX_STEPS   (MAXS)
    ) dut (
        .FAB_CLK                 (FAB_CLK),
        .ARST_N                  (ARST_N),
        .START                   (START),
        .EYE_MONITOR_EARLY       (EYE_MONITOR_EARLY),
        .EYE_MONITOR_LATE        (EYE_MONITOR_LATE),
        .DELAY_LINE_OUT_OF_RANGE (DELAY_LINE_OUT_OF_RANGE),
        .DELAY_LINE_LOAD         (DELAY_LINE_LOAD),
        .DELAY_LINE_MOVE         (DELAY_LINE_MOVE),
        .DELAY_LINE_DIRECTION    (DELAY_LINE_DIRECTION),
        .EYE_MONITOR_CLEAR_FLAGS (EYE_MONITOR_CLEAR_FLAGS),
        .BUSY                    (BUSY),
        .DONE                    (DONE),
        .FAIL                    (FAIL),
        .TAP_OFFSET              (TAP_OFFSET)
    );

    initial FAB_CLK = 1'b0;
    always #5 FAB_CLK = ~FAB_CLK;

    int n_vec = 0;
    int n_bad = 0;

    // Direction the delay line was last told; only a move or reset changes it.
    bit m_dir = 1'b0;

    // Per-sample flags {oor, late, early}
    logic [2:0] plan[$];

    // Pulse counters, sampled on the falling edge
    int cnt_load  = 0;
    int cnt_clear = 0;
    int cnt_move  = 0;

    always @(negedge FAB_CLK) begin
        if (ARST_N) begin
            cnt_load  += int'(DELAY_LINE_LOAD);
            cnt_clear += int'(EYE_MONITOR_CLEAR_FLAGS);
            cnt_move  += int'(DELAY_LINE_MOVE);
        end
    end

    task automatic step();
        @(posedge FAB_CLK);
        #1;
    endtask

    function automatic logic [14:0] obs();
        return {DELAY_LINE_LOAD, DELAY_LINE_MOVE, EYE_MONITOR_CLEAR_FLAGS, BUSY,
                DONE, FAIL, DELAY_LINE_DIRECTION, TAP_OFFSET};
    endfunction

    function automatic logic [14:0] ex(bit ld, bit mv, bit cl, bit bs, bit dn,
                                       bit fl, bit dr, int tap);
        logic [7:0] t;
        t = 8'(tap);
        return {ld, mv, cl, bs, dn, fl, dr, t};
    endfunction

    task automatic chk(input string tag, input logic [14:0] o, input logic [14:0] e);
        n_vec++;
        assert (o === e) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    // One complete training run driven from 'plan'. abort_moves >= 1 pulls
    // ARST_N low inside WAIT once that many moves have been made.
    task automatic run_training(input string tag, input int abort_moves);
        int         tap     = 0;
        int         lock    = 0;
        int         moves   = 0;
        int         samples = 0;
        int         nt;
        bit         fin     = 1'b0;
        bit         lim;
        logic [2:0] f;
        string      res     = "open";

        START = 1'b1;
        step();
        START = 1'b0;
        chk({tag, "/load"}, obs(), ex(1, 0, 0, 1, 0, 0, m_dir, 0));
        step();

        while (!fin) begin
            chk({tag, "/clear"}, obs(), ex(0, 0, 1, 1, 0, 0, m_dir, tap));
            chk({tag, "/budget"}, 15'(samples < 1000), 15'd1);
            if (EYE_MONITOR_CLEAR_FLAGS !== 1'b1 || samples >= 1000) begin
                res = "lost";
                break;
            end

            if (abort_moves > 0 && moves == abort_moves) begin
                step();
                step();
                #2;
                ARST_N = 1'b0;
                #1;
                m_dir = 1'b0;
                chk({tag, "/async_rst"}, obs(), 15'd0);
                res = "reset";
                break;
            end

            f = (plan.size() > 0) ? plan.pop_front() : 3'b000;

            // Flags are noise during WAIT; only the value present at SAMPLE counts.
            repeat (W) begin
                step();
                START                   = 1'($urandom_range(0, 1));
                EYE_MONITOR_EARLY       = 1'($urandom_range(0, 1));
                EYE_MONITOR_LATE        = 1'($urandom_range(0, 1));
                DELAY_LINE_OUT_OF_RANGE = 1'($urandom_range(0, 1));
            end
            step();
            chk({tag, "/sample"}, obs(), ex(0, 0, 0, 1, 0, 0, m_dir, tap));
            EYE_MONITOR_EARLY       = f[0];
            EYE_MONITOR_LATE        = f[1];
            DELAY_LINE_OUT_OF_RANGE = f[2];
            START                   = 1'($urandom_range(0, 1));
            step();
            START = 1'b0;
            samples++;

            lim = 1'b0;
`ifdef DQS_DLY_TRAIN_STEP_LIMIT_EN
            lim = (moves == MAXS);
`endif
            if (f[2] || lim) begin
                chk({tag, "/fail"}, obs(), ex(0, 0, 0, 0, 0, 1, m_dir, tap));
                res = "fail";
                fin = 1'b1;
            end else if (f[0] && f[1]) begin
                lock = 0;
            end else if (f[0] || f[1]) begin
                nt = tap + (f[0] ? 1 : -1);
                if (nt > 127 || nt < -128) begin
                    chk({tag, "/sat_fail"}, obs(), ex(0, 0, 0, 0, 0, 1, m_dir, tap));
                    res = "fail";
                    fin = 1'b1;
                end else begin
                    tap   = nt;
                    m_dir = f[0];
                    lock  = 0;
                    moves++;
                    chk({tag, "/move"}, obs(), ex(0, 1, 0, 1, 0, 0, m_dir, tap));
                    step();
                end
            end else begin
                lock++;
                if (lock == LOCK) begin
                    chk({tag, "/done"}, obs(), ex(0, 0, 0, 0, 1, 0, m_dir, tap));
                    step();
                    chk({tag, "/done_hold"}, obs(), ex(0, 0, 0, 0, 1, 0, m_dir, tap));
                    res = "done";
                    fin = 1'b1;
                end
            end
        end
        plan.delete();
        $display("run %s: samples=%0d moves=%0d tap=%0d result=%s",
                 tag, samples, moves, tap, res);
    endtask

    int         c_load, c_clear, c_move;
    int         len, p;
    logic [2:0] v;

    initial begin
        ARST_N                  = 1'b0;
        START                   = 1'b0;
        EYE_MONITOR_EARLY       = 1'b0;
        EYE_MONITOR_LATE        = 1'b0;
        DELAY_LINE_OUT_OF_RANGE = 1'b0;

        // Reset state, then IDLE with START low
        #12;
        chk("reset", obs(), 15'd0);
        ARST_N = 1'b1;
        repeat (3) begin
            step();
            chk("idle", obs(), 15'd0);
        end

        // Clean flags: 1 LOAD, LOCK CLEARs, no MOVE, DONE at tap 0
        c_load = cnt_load; c_clear = cnt_clear; c_move = cnt_move;
        run_training("clean", 0);
        chk("clean/n_load",  15'(cnt_load  - c_load),  15'd1);
        chk("clean/n_clear", 15'(cnt_clear - c_clear), 15'(LOCK));
        chk("clean/n_move",  15'(cnt_move  - c_move),  15'd0);

        // Three early samples, then clean
        repeat (3) plan.push_back(3'b001);
        run_training("early3", 0);

        // Early and late together on every sample: never moves
        c_move = cnt_move;
        repeat (6) plan.push_back(3'b011);
        run_training("both", 0);
        chk("both/n_move", 15'(cnt_move - c_move), 15'd0);

        // Out-of-range while late
        plan.push_back(3'b010);
        plan.push_back(3'b010);
        plan.push_back(3'b110);
        c_move = cnt_move;
        run_training("oor", 0);
        chk("oor/n_move", 15'(cnt_move - c_move), 15'd2);

        // Reset inside WAIT after two moves, then restart from LOAD
        plan.push_back(3'b001);
        plan.push_back(3'b001);
        run_training("rst_mid", 2);
        #2;
        ARST_N = 1'b1;
        repeat (4) begin
            step();
            chk("rst_idle", obs(), 15'd0);
        end
        run_training("restart", 0);

`ifdef DQS_DLY_TRAIN_STEP_LIMIT_EN
        c_move = cnt_move;
        repeat (20) plan.push_back(3'b001);
        run_training("step_limit", 0);
        chk("step_limit/n_move", 15'(cnt_move - c_move), 15'(MAXS));
`endif

        // Tap saturation at both ends
        repeat (128) plan.push_back(3'b001);
        run_training("sat_pos", 0);
        repeat (129) plan.push_back(3'b010);
        run_training("sat_neg", 0);

        // Randomized flag sequences
        for (int r = 0; r < 12; r++) begin
            len = $urandom_range(0, 12);
            for (int k = 0; k < len; k++) begin
                p = $urandom_range(0, 15);
                v = 3'($urandom_range(0, 3));
                if (p == 0) v[2] = 1'b1;
                plan.push_back(v);
            end
            run_training($sformatf("rand%0d", r), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
